cond_exec_unit: RTL and testbench

- Registered, handshaked successor to the combinational condition evaluator.
- Holds NUM_CTX independent NZCV flag contexts and evaluates each instruction's 4-bit ARM condition against its context.
- Supports a predicate-block (IT-style) mode covering up to IT_MAX following instructions.
- Sits between decode and execute; issues one execute-enable per accepted instruction.

---
 rtl/cond_exec_unit.sv | 205 ++++++++++++++++++++
 tb/tb_cond_exec_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_unit.sv
// Registered, handshaked ARM condition evaluator with per-context NZCV flags
// and a single IT-style predicate-block tracker shared by all contexts.
module cond_exec_unit #(
    parameter int NUM_CTX   = 2,
    parameter int IT_MAX    = 4,
    parameter int NV_ALWAYS = 0,
    parameter int TAG_W     = 8,
    localparam int CTX_W    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
    localparam int LEN_W    = $clog2(IT_MAX + 1)
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_valid,
    output logic                 out_in_ready,
    input  logic [CTX_W-1:0]     in_ctx,
    input  logic [3:0]           in_cond,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 in_set_flags,
    input  logic [3:0]           in_flags_new,
    input  logic                 in_it_start,
    input  logic [LEN_W-1:0]     in_it_len,
    input  logic [IT_MAX-1:0]    in_it_mask,
    input  logic                 in_msr_en,
    input  logic [CTX_W-1:0]     in_msr_ctx,
    input  logic [3:0]           in_msr_flags,
    output logic                 out_valid,
    input  logic                 in_out_ready,
    output logic                 out_execute_en,
    output logic [TAG_W-1:0]     out_tag,
    output logic [CTX_W-1:0]     out_ctx,
    output logic                 out_it_err,
    output logic [4*NUM_CTX-1:0] out_flags
);

    typedef enum logic {IDLE, BLOCK} state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          flags [NUM_CTX];
    logic [CTX_W-1:0]    block_ctx;
    logic [3:0]          block_cond;
    logic [IT_MAX-1:0]   block_mask;
    logic [LEN_W-1:0]    block_len;
    logic [LEN_W-1:0]    block_cnt;

    logic                accept;
    logic [3:0]          cur_flags;
    logic [LEN_W-1:0]    slot;
    logic                mask_bit;
    logic [LEN_W-1:0]    eff_len;
    logic                in_block_beat;
    logic                block_pass;
    logic                block_fail;
    logic                exec;
    logic                it_err;
    logic                load_block;
    logic                consume;
    logic                write_flags;

    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        {n, z, c, v} = f;
        r = 1'b0;
        case (cond)
            4'h0:    r = z;
            4'h1:    r = ~z;
            4'h2:    r = c;
            4'h3:    r = ~c;
            4'h4:    r = n;
            4'h5:    r = ~n;
            4'h6:    r = v;
            4'h7:    r = ~v;
            4'h8:    r = c & ~z;
            4'h9:    r = ~c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = ~z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = (NV_ALWAYS != 0);
        endcase
        return r;
    endfunction

    assign out_in_ready = ~out_valid | in_out_ready;
    assign accept       = in_valid & out_in_ready;

    always_comb begin
        cur_flags = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (in_ctx == CTX_W'(i)) cur_flags = flags[i];
        end

        slot     = block_len - block_cnt;
        mask_bit = 1'b0;
        for (int i = 0; i < IT_MAX; i++) begin
            if (slot == LEN_W'(i)) mask_bit = block_mask[i];
        end

        if (in_it_len == '0)
            eff_len = LEN_W'(1);
        else if (in_it_len > LEN_W'(IT_MAX))
            eff_len = LEN_W'(IT_MAX);
        else
            eff_len = in_it_len;

        // Inverted slots of AL/NV never execute, regardless of NV_ALWAYS.
        block_pass = eval_cond(block_cond, cur_flags);
        block_fail = (block_cond >= 4'hE) ? 1'b0 : ~block_pass;

        in_block_beat = (state == BLOCK) && (in_ctx == block_ctx);
        exec          = 1'b0;
        it_err        = 1'b0;
        load_block    = 1'b0;
        consume       = 1'b0;

        if (in_block_beat) begin
            consume = 1'b1;
            exec    = mask_bit ? block_pass : block_fail;
            it_err  = in_it_start;
        end else if ((state == IDLE) && in_it_start) begin
            exec       = 1'b1;
            load_block = 1'b1;
        end else begin
            exec = eval_cond(in_cond, cur_flags);
        end

        write_flags = accept & in_set_flags & exec & ~in_it_start;
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            if (load_block)
                state_next = BLOCK;
            else if (consume && (block_cnt == LEN_W'(1)))
                state_next = IDLE;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            block_ctx  <= '0;
            block_cond <= '0;
            block_mask <= '0;
            block_len  <= '0;
            block_cnt  <= '0;
        end else if (accept) begin
            if (load_block) begin
                block_ctx  <= in_ctx;
                block_cond <= in_cond;
                block_mask <= in_it_mask;
                block_len  <= eff_len;
                block_cnt  <= eff_len;
            end else if (consume) begin
                block_cnt <= block_cnt - LEN_W'(1);
            end
        end
    end

    // A direct MSR write takes priority over an instruction write to the same context.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < NUM_CTX; i++) flags[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (in_msr_en && (in_msr_ctx == CTX_W'(i)))
                    flags[i] <= in_msr_flags;
                else if (write_flags && (in_ctx == CTX_W'(i)))
                    flags[i] <= in_flags_new;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_valid      <= 1'b0;
            out_execute_en <= 1'b0;
            out_tag        <= '0;
            out_ctx        <= '0;
            out_it_err     <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_execute_en <= exec;
            out_tag        <= in_tag;
            out_ctx        <= in_ctx;
            out_it_err     <= it_err;
        end else if (in_out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_comb begin
        out_flags = '0;
        for (int i = 0; i < NUM_CTX; i++) out_flags[i*4 +: 4] = flags[i];
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed-vector bench for cond_exec_unit; a second instance with NV_ALWAYS=1
// shares all inputs so the cond 4'b1111 behaviour can be compared side by side.
module tb_cond_exec_unit;

    localparam int CTX_W = 1;
    localparam int LEN_W = 3;
    localparam int IT_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              out_in_ready, nv_in_ready;
    logic [CTX_W-1:0]  in_ctx;
    logic [3:0]        in_cond;
    logic [7:0]        in_tag;
    logic              in_set_flags;
    logic [3:0]        in_flags_new;
    logic              in_it_start;
    logic [LEN_W-1:0]  in_it_len;
    logic [IT_MAX-1:0] in_it_mask;
    logic              msr_en;
    logic [CTX_W-1:0]  msr_ctx;
    logic [3:0]        msr_flags;
    logic              out_valid, nv_valid;
    logic              out_ready;
    logic              exec_en, nv_exec_en;
    logic [7:0]        out_tag, nv_tag;
    logic [CTX_W-1:0]  out_ctx, nv_ctx;
    logic              it_err, nv_it_err;
    logic [7:0]        out_flags, nv_flags;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cond_exec_unit #(.NUM_CTX(2), .IT_MAX(4), .NV_ALWAYS(0), .TAG_W(8)) dut (
        .in_clk(clk), .in_rst(rst), .in_valid(in_valid), .out_in_ready(out_in_ready),
        .in_ctx(in_ctx), .in_cond(in_cond), .in_tag(in_tag), .in_set_flags(in_set_flags),
        .in_flags_new(in_flags_new), .in_it_start(in_it_start), .in_it_len(in_it_len),
        .in_it_mask(in_it_mask), .in_msr_en(msr_en), .in_msr_ctx(msr_ctx),
        .in_msr_flags(msr_flags), .out_valid(out_valid), .in_out_ready(out_ready),
        .out_execute_en(exec_en), .out_tag(out_tag), .out_ctx(out_ctx),
        .out_it_err(it_err), .out_flags(out_flags)
    );

    cond_exec_unit #(.NUM_CTX(2), .IT_MAX(4), .NV_ALWAYS(1), .TAG_W(8)) dut_nv (
        .in_clk(clk), .in_rst(rst), .in_valid(in_valid), .out_in_ready(nv_in_ready),
        .in_ctx(in_ctx), .in_cond(in_cond), .in_tag(in_tag), .in_set_flags(in_set_flags),
        .in_flags_new(in_flags_new), .in_it_start(in_it_start), .in_it_len(in_it_len),
        .in_it_mask(in_it_mask), .in_msr_en(msr_en), .in_msr_ctx(msr_ctx),
        .in_msr_flags(msr_flags), .out_valid(nv_valid), .in_out_ready(out_ready),
        .out_execute_en(nv_exec_en), .out_tag(nv_tag), .out_ctx(nv_ctx),
        .out_it_err(nv_it_err), .out_flags(nv_flags)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one beat for a single edge (accepted when ready) and leaves valid low.
    task automatic applyStimulus(input logic [CTX_W-1:0] ctx, input logic [3:0] cond,
                                 input logic [7:0] tag, input logic set_flags,
                                 input logic [3:0] flags_new, input logic it_start,
                                 input logic [LEN_W-1:0] it_len,
                                 input logic [IT_MAX-1:0] it_mask);
        in_valid     = 1'b1;
        in_ctx       = ctx;
        in_cond      = cond;
        in_tag       = tag;
        in_set_flags = set_flags;
        in_flags_new = flags_new;
        in_it_start  = it_start;
        in_it_len    = it_len;
        in_it_mask   = it_mask;
        tick();
        in_valid     = 1'b0;
        in_set_flags = 1'b0;
        in_it_start  = 1'b0;
    endtask

    task automatic applyMsr(input logic [CTX_W-1:0] ctx, input logic [3:0] value);
        msr_en    = 1'b1;
        msr_ctx   = ctx;
        msr_flags = value;
        tick();
        msr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_ctx = '0; in_cond = '0; in_tag = '0; in_set_flags = 1'b0;
        in_flags_new = '0; in_it_start = 1'b0; in_it_len = '0; in_it_mask = '0;
        msr_en = 1'b0; msr_ctx = '0; msr_flags = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset exec_en", exec_en, 0);
        checkOutput("reset tag", out_tag, 0);
        checkOutput("reset it_err", it_err, 0);
        checkOutput("reset flags", out_flags, 0);
        checkOutput("reset in_ready", out_in_ready, 1);

        // Basic EQ/NE with Z set
        applyMsr(0, 4'b0100);
        checkOutput("msr ctx0", out_flags, 8'h04);
        applyStimulus(0, 4'h0, 8'h11, 0, 0, 0, 0, 0);
        checkOutput("EQ valid", out_valid, 1);
        checkOutput("EQ exec", exec_en, 1);
        checkOutput("EQ tag", out_tag, 8'h11);
        applyStimulus(0, 4'h1, 8'h12, 0, 0, 0, 0, 0);
        checkOutput("NE exec", exec_en, 0);
        applyStimulus(0, 4'h9, 8'h13, 0, 0, 0, 0, 0);
        checkOutput("LS exec", exec_en, 1);

        // N=0 V=1 Z=0
        applyMsr(0, 4'b0001);
        applyStimulus(0, 4'hD, 8'h14, 0, 0, 0, 0, 0);
        checkOutput("LE exec", exec_en, 1);
        applyStimulus(0, 4'hC, 8'h15, 0, 0, 0, 0, 0);
        checkOutput("GT exec", exec_en, 0);
        applyStimulus(0, 4'hF, 8'h16, 0, 0, 0, 0, 0);
        checkOutput("NV never exec", exec_en, 0);
        checkOutput("NV always exec", nv_exec_en, 1);

        // Back-to-back flag forwarding through the register
        applyStimulus(0, 4'hE, 8'h21, 1, 4'b0100, 0, 0, 0);
        checkOutput("b2b beat1 exec", exec_en, 1);
        applyStimulus(0, 4'h0, 8'h22, 0, 0, 0, 0, 0);
        checkOutput("b2b beat2 exec", exec_en, 1);
        applyStimulus(1, 4'h0, 8'h23, 0, 0, 0, 0, 0);
        checkOutput("ctx1 EQ exec", exec_en, 0);
        checkOutput("ctx1 out_ctx", out_ctx, 1);
        checkOutput("b2b flags", out_flags, 8'h04);

        // Downstream stall: beat must wait and not touch flags
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctx = 0; in_cond = 4'hE; in_tag = 8'h33;
        in_set_flags = 1'b1; in_flags_new = 4'b1111; in_it_start = 1'b0;
        #1;
        checkOutput("stall in_ready", out_in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall in_ready", out_in_ready, 0);
            checkOutput("stall valid", out_valid, 1);
            checkOutput("stall tag", out_tag, 8'h23);
            checkOutput("stall flags", out_flags, 8'h04);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_set_flags = 1'b0;
        checkOutput("release tag", out_tag, 8'h33);
        checkOutput("release exec", exec_en, 1);
        checkOutput("release flags", out_flags, 8'h0F);
        tick();
        checkOutput("accepted once", out_valid, 0);

        // Predicate block EQ, len 3, mask 101 with Z=1
        applyMsr(0, 4'b0100);
        applyStimulus(0, 4'h0, 8'h40, 0, 0, 1, 3, 4'b0101);
        checkOutput("opener exec", exec_en, 1);
        checkOutput("opener it_err", it_err, 0);
        applyStimulus(0, 4'hE, 8'h41, 0, 0, 0, 0, 0);
        checkOutput("slot0 exec", exec_en, 1);
        applyStimulus(1, 4'h1, 8'h42, 0, 0, 0, 0, 0);
        checkOutput("ctx1 interleave exec", exec_en, 1);
        applyStimulus(0, 4'hE, 8'h43, 0, 0, 0, 0, 0);
        checkOutput("slot1 exec", exec_en, 0);
        applyStimulus(0, 4'hE, 8'h44, 1, 4'b0000, 1, 2, 4'b0000);
        checkOutput("slot2 nested exec", exec_en, 1);
        checkOutput("slot2 it_err", it_err, 1);
        checkOutput("nested no flag write", out_flags, 8'h04);
        applyStimulus(0, 4'h1, 8'h45, 0, 0, 0, 0, 0);
        checkOutput("post-block NE exec", exec_en, 0);
        checkOutput("post-block it_err", it_err, 0);

        // MSR vs instruction write on the same edge
        msr_en = 1'b1; msr_ctx = 0; msr_flags = 4'b0001;
        applyStimulus(0, 4'hE, 8'h50, 1, 4'b1000, 0, 0, 0);
        msr_en = 1'b0;
        checkOutput("msr wins same ctx", out_flags, 8'h01);
        msr_en = 1'b1; msr_ctx = 1; msr_flags = 4'b0010;
        applyStimulus(0, 4'hE, 8'h51, 1, 4'b1000, 0, 0, 0);
        msr_en = 1'b0;
        checkOutput("msr and write diff ctx", out_flags, 8'h28);

        // Length 0 behaves as a one-slot block
        applyStimulus(0, 4'hE, 8'h60, 0, 0, 1, 0, 4'b0000);
        applyStimulus(0, 4'hE, 8'h61, 0, 0, 0, 0, 0);
        checkOutput("len0 slot0 exec", exec_en, 0);
        applyStimulus(0, 4'hE, 8'h62, 0, 0, 0, 0, 0);
        checkOutput("len0 after block exec", exec_en, 1);

        // Length 7 clamps to four slots
        applyStimulus(0, 4'hE, 8'h70, 0, 0, 1, 7, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 4'hE, 8'h71, 0, 0, 0, 0, 0);
            checkOutput("clamp slot exec", exec_en, 0);
        end
        applyStimulus(0, 4'hE, 8'h72, 0, 0, 0, 0, 0);
        checkOutput("clamp after block exec", exec_en, 1);

        // Reset mid-block aborts it
        applyStimulus(0, 4'hE, 8'h80, 0, 0, 1, 4, 4'b0000);
        applyStimulus(0, 4'hE, 8'h81, 0, 0, 0, 0, 0);
        checkOutput("mid-block slot0 exec", exec_en, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid reset valid", out_valid, 0);
        checkOutput("mid reset flags", out_flags, 0);
        applyStimulus(0, 4'hE, 8'h82, 0, 0, 0, 0, 0);
        checkOutput("after reset AL exec", exec_en, 1);
        checkOutput("after reset tag", out_tag, 8'h82);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
